// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and constants for the pipeline control unit.
//   state_e  : control FSM states (RUN, DIV_WAIT, BUS_WAIT)
//   hold_t   : bundle of the three hold flags driven to the pipeline
//   NOP_INSN : bubble encoding (addi x0,x0,0) used by a stage's set_data
//              path when it chooses to insert a bubble
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_BUS_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
  } hold_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Hold pattern with every stage frozen or every stage free.
  function automatic hold_t hold_all(input logic v);
    hold_t h;
    h.pc    = v;
    h.if_id = v;
    h.id_ex = v;
    return h;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
// Request/response bundle between the datapath and the pipeline control
// unit.
//   master : datapath side; drives hazard/stall requests and the jump
//            target, receives PC load, hold flags, bus error and counters
//   slave  : pipe_ctrl side
// Parameter AW sets the jump address width.
interface pipe_ctrl_if #(
  parameter int AW = 32
);

  logic          jump_i;
  logic [AW-1:0] jump_addr_i;
  logic          lu_hazard_i;
  logic          div_start_i;
  logic          div_done_i;
  logic          bus_hold_i;
  logic          jump_o;
  logic [AW-1:0] jump_addr_o;
  logic          hold_pc_o;
  logic          hold_if_id_o;
  logic          hold_id_ex_o;
  logic          bus_err_o;
  logic [31:0]   stall_cnt_o;
  logic [31:0]   flush_cnt_o;

  modport master (
    output jump_i, jump_addr_i, lu_hazard_i, div_start_i, div_done_i,
           bus_hold_i,
    input  jump_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
           bus_err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  jump_i, jump_addr_i, lu_hazard_i, div_start_i, div_done_i,
           bus_hold_i,
    output jump_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
           bus_err_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_tmo.sv
// pipe_ctrl_tmo
// Bus-wait timeout counter: clear / enable / saturating up-counter.
//   clk, rst : clock, asynchronous active-low reset
//   clr_i    : synchronous clear (dominates enable)
//   en_i     : count one more wait cycle
//   tc_o     : high while enabled in the LIMIT-th counted cycle
// The counter holds LIMIT-1 at most, so it never wraps even if the owner
// keeps it enabled after the terminal count.
module pipe_ctrl_tmo #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_r;

  // Wait-cycle counter, saturating at the terminal value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr_i) begin
      cnt_r <= {W{1'b0}};
    end else if (en_i && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // cnt_r counts completed cycles, so the current cycle is the LIMIT-th
  // when cnt_r sits at LIMIT-1.
  assign tc_o = en_i && (cnt_r == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Pipeline control unit for the 5-stage core. Collects the EX jump,
// load-use hazard, multi-cycle divide and bus-wait requests and drives the
// hold flags of the PC, IF/ID and ID/EX registers, plus the PC redirect.
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset; all outputs read 0 while low
//   pc_if  : pipe_ctrl_if.slave bundle (requests in, holds/redirect out)
// Parameters: AW jump address width, TMO_W timeout counter width,
//   BUS_TMO bus-wait cycles before a timeout (1 .. 2**TMO_W-1).
// Build option: define PIPE_CTRL_PERF_EN to get the stall/flush
//   performance counters; otherwise both counter outputs are tied to 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TMO_W   = 8,
  parameter int BUS_TMO = 255
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave pc_if
);

  state_e        state_r;
  logic          bus_err_r;
  logic          tmo_tc_s;
  logic          jump_s;
  logic [AW-1:0] jump_addr_s;
  hold_t         hold_s;

  pipe_ctrl_tmo #(
    .W     (TMO_W),
    .LIMIT (BUS_TMO)
  ) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_r != ST_BUS_WAIT),
    .en_i  (state_r == ST_BUS_WAIT),
    .tc_o  (tmo_tc_s)
  );

  // Control FSM with the registered bus-error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_RUN;
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          // Divide wins over a simultaneous bus wait.
          if (pc_if.div_start_i) begin
            state_r <= ST_DIV_WAIT;
          end else if (pc_if.bus_hold_i) begin
            state_r <= ST_BUS_WAIT;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DIV_WAIT: begin
          // Bus hold and repeated div_start are ignored until the result.
          if (pc_if.div_done_i) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_DIV_WAIT;
          end
        end
        ST_BUS_WAIT: begin
          // A bus that becomes ready on the last allowed cycle is not an
          // error.
          if (!pc_if.bus_hold_i) begin
            state_r <= ST_RUN;
          end else if (tmo_tc_s) begin
            state_r   <= ST_RUN;
            bus_err_r <= 1'b1;
          end else begin
            state_r <= ST_BUS_WAIT;
          end
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

  // Prioritised hold / redirect decode; everything is zero while in reset
  always_comb begin
    jump_s      = 1'b0;
    jump_addr_s = {AW{1'b0}};
    hold_s      = hold_all(1'b0);
    if (!rst) begin
      hold_s = hold_all(1'b0);
    end else if (pc_if.jump_i) begin
      // Redirect flushes IF/ID and ID/EX; PC must stay free to load.
      // A same-cycle load-use hazard is moot because ID is flushed.
      jump_s       = 1'b1;
      jump_addr_s  = pc_if.jump_addr_i;
      hold_s.if_id = 1'b1;
      hold_s.id_ex = 1'b1;
    end else if ((state_r == ST_DIV_WAIT) && !pc_if.div_done_i) begin
      hold_s = hold_all(1'b1);
    end else if ((state_r == ST_BUS_WAIT) ||
                 ((state_r == ST_RUN) && pc_if.bus_hold_i)) begin
      // Front end frozen, ID/EX keeps draining.
      hold_s.pc    = 1'b1;
      hold_s.if_id = 1'b1;
    end else if ((state_r == ST_RUN) && pc_if.lu_hazard_i) begin
      hold_s = hold_all(1'b1);
    end else begin
      hold_s = hold_all(1'b0);
    end
  end

  assign pc_if.jump_o       = jump_s;
  assign pc_if.jump_addr_o  = jump_addr_s;
  assign pc_if.hold_pc_o    = hold_s.pc;
  assign pc_if.hold_if_id_o = hold_s.if_id;
  assign pc_if.hold_id_ex_o = hold_s.id_ex;
  assign pc_if.bus_err_o    = bus_err_r;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Performance counters: stalled PC cycles and taken redirects, wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (hold_s.pc) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (jump_s) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign pc_if.stall_cnt_o = stall_cnt_r;
  assign pc_if.flush_cnt_o = flush_cnt_r;
`else
  assign pc_if.stall_cnt_o = 32'd0;
  assign pc_if.flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Scoreboard bench for pipe_ctrl. A driver applies directed and random
// requests one cycle at a time, computes the expected outputs from a
// behavioural model of the control rules and queues them; a monitor pops
// and compares at each falling edge. PIPE_CTRL_PERF_EN selects whether
// the counter outputs are expected to count or to stay at 0.
module tb_pipe_ctrl;

  localparam int AW  = 32;
  localparam int TMO = 4;

  typedef struct {
    logic        jump;
    logic [31:0] addr;
    logic        hpc;
    logic        hifid;
    logic        hidex;
    logic        err;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.AW(AW)) bus_if ();

  pipe_ctrl #(.AW(AW), .TMO_W(8), .BUS_TMO(TMO)) dut (
    .clk   (clk),
    .rst   (rst),
    .pc_if (bus_if)
  );

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Behavioural model: what kind of stall is pending, how long the bus
  // has been waiting, whether an error pulse is due, and event counts.
  bit          m_div_wait;
  bit          m_bus_wait;
  int          m_bus_cycles;
  bit          m_err_due;
  logic [31:0] m_stalls;
  logic [31:0] m_jumps;

  task automatic model_reset();
    m_div_wait   = 1'b0;
    m_bus_wait   = 1'b0;
    m_bus_cycles = 0;
    m_err_due    = 1'b0;
    m_stalls     = 32'd0;
    m_jumps      = 32'd0;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus plus its expected response.
  task automatic step(bit j, logic [31:0] a, bit lu, bit ds, bit dd, bit bh, bit r);
    exp_t e;
    bit   running;
    @(posedge clk);
    #1;
    rst                = r;
    bus_if.jump_i      = j;
    bus_if.jump_addr_i = a;
    bus_if.lu_hazard_i = lu;
    bus_if.div_start_i = ds;
    bus_if.div_done_i  = dd;
    bus_if.bus_hold_i  = bh;
    e.jump  = 1'b0; e.addr  = 32'd0; e.hpc = 1'b0; e.hifid = 1'b0;
    e.hidex = 1'b0; e.err   = 1'b0;  e.sc  = 32'd0; e.fc   = 32'd0;
    if (!r) begin
      model_reset();
    end else begin
      running = !m_div_wait && !m_bus_wait;
      e.err = m_err_due;
`ifdef PIPE_CTRL_PERF_EN
      e.sc = m_stalls;
      e.fc = m_jumps;
`endif
      if (j) begin
        e.jump = 1'b1; e.addr = a; e.hifid = 1'b1; e.hidex = 1'b1;
      end else if (m_div_wait && !dd) begin
        e.hpc = 1'b1; e.hifid = 1'b1; e.hidex = 1'b1;
      end else if (m_bus_wait || (running && bh)) begin
        e.hpc = 1'b1; e.hifid = 1'b1;
      end else if (running && lu) begin
        e.hpc = 1'b1; e.hifid = 1'b1; e.hidex = 1'b1;
      end
      // Where the unit stands after this cycle.
      m_err_due = 1'b0;
      if (m_div_wait) begin
        if (dd) m_div_wait = 1'b0;
      end else if (m_bus_wait) begin
        if (!bh) begin
          m_bus_wait = 1'b0;
        end else if (m_bus_cycles + 1 == TMO) begin
          m_bus_wait = 1'b0;
          m_err_due  = 1'b1;
        end else begin
          m_bus_cycles++;
        end
      end else if (ds) begin
        m_div_wait = 1'b1;
      end else if (bh) begin
        m_bus_wait   = 1'b1;
        m_bus_cycles = 0;
      end
      m_stalls = m_stalls + 32'(e.hpc);
      m_jumps  = m_jumps + 32'(e.jump);
    end
    q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare DUT outputs against the queued expectation mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("jump_o",       32'(bus_if.jump_o),       32'(e.jump));
        check("jump_addr_o",  bus_if.jump_addr_o,       e.addr);
        check("hold_pc_o",    32'(bus_if.hold_pc_o),    32'(e.hpc));
        check("hold_if_id_o", 32'(bus_if.hold_if_id_o), 32'(e.hifid));
        check("hold_id_ex_o", 32'(bus_if.hold_id_ex_o), 32'(e.hidex));
        check("bus_err_o",    32'(bus_if.bus_err_o),    32'(e.err));
        check("stall_cnt_o",  bus_if.stall_cnt_o,       e.sc);
        check("flush_cnt_o",  bus_if.flush_cnt_o,       e.fc);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    bit j, lu, ds, dd, bh, r;
    logic [31:0] a;
    model_reset();
    bus_if.jump_i      = 1'b0;
    bus_if.jump_addr_i = 32'd0;
    bus_if.lu_hazard_i = 1'b0;
    bus_if.div_start_i = 1'b0;
    bus_if.div_done_i  = 1'b0;
    bus_if.bus_hold_i  = 1'b0;

    // Reset state, with a jump request present to show outputs are forced low.
    step(1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Idle.
    idle(10);
    // Jump with a same-cycle load-use hazard, then a plain load-use bubble.
    step(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Divide: start at t, done at t+33; a late done in RUN is ignored.
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(32);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);
    // Bus timeout: bus_hold held high well past BUS_TMO.
    for (int i = 0; i < 14; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    // Divide priority over a simultaneous bus hold, bus hold ignored inside.
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);
    // Reset mid-divide, then a late div_done after release.
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Random traffic; bus_hold is sticky so that timeouts also occur.
    bh = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      j  = ($urandom_range(0, 7) == 0);
      a  = $urandom;
      lu = ($urandom_range(0, 3) == 0);
      ds = ($urandom_range(0, 9) == 0);
      dd = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 5) == 0) bh = ~bh;
      r  = ($urandom_range(0, 299) != 0);
      step(j, a, lu, ds, dd, bh, r);
    end
    idle(3);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 5-stage RISC core. It gathers hazard and stall requests (EX-stage jump, load-use hazard, multi-cycle divide, bus wait) and drives the `hold_flag_i` inputs of the PC register and the IF/ID and ID/EX pipeline registers. It also forwards the redirect target to the PC. It sits beside the datapath and owns no datapath state, only its own FSM and counters.

## Interface
- `AW`, 32, address width of the jump target.
- `TMO_W`, 8, bus-wait timeout counter width.
- `BUS_TMO`, 255, bus-wait cycles before timeout; range 1 to 2^TMO_W−1.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `jump_i`  in  1  EX-stage redirect request.
- `jump_addr_i`  in  AW  redirect target.
- `lu_hazard_i`  in  1  ID-stage load-use hazard.
- `div_start_i`  in  1  single-cycle pulse; divider accepted operands.
- `div_done_i`  in  1  single-cycle pulse; divider result valid.
- `bus_hold_i`  in  1  instruction/data bus not ready.
- `jump_o`  out  1  PC load enable.
- `jump_addr_o`  out  AW  PC load value.
- `hold_pc_o`  out  1  to PC register `hold_flag_i`.
- `hold_if_id_o`  out  1  to IF/ID `hold_flag_i`.
- `hold_id_ex_o`  out  1  to ID/EX `hold_flag_i`.
- `bus_err_o`  out  1  one-cycle pulse on bus-wait timeout.
- `stall_cnt_o`  out  32  cycles with `hold_pc_o`=1.
- `flush_cnt_o`  out  32  count of jumps taken.

## Operation
- Each stage's `set_data` choice (NOP bubble or value feedback) is made in the stage. This block only asserts the hold flags.
- FSM states and transitions:
  - **RUN**: `div_start_i` goes to DIV_WAIT. Otherwise `bus_hold_i` goes to BUS_WAIT. Divide has priority over bus wait.
  - **DIV_WAIT**: `div_done_i` returns to RUN. `bus_hold_i` is ignored in this state.
  - **BUS_WAIT**: `bus_hold_i`=0 returns to RUN. Timeout counter reaching `BUS_TMO` also returns to RUN and pulses `bus_err_o`.
- Outputs are combinational from state and inputs, with this priority:
  1. `jump_i`=1 in any state: `jump_o`=1, `jump_addr_o`=`jump_addr_i`, `hold_if_id_o`=`hold_id_ex_o`=1, `hold_pc_o`=0. Any `lu_hazard_i` in the same cycle is dropped.
  2. DIV_WAIT with `div_done_i`=0: all three holds =1.
  3. BUS_WAIT, or RUN with `bus_hold_i`=1: `hold_pc_o`=`hold_if_id_o`=1, `hold_id_ex_o`=0.
  4. RUN with `lu_hazard_i`=1: `hold_pc_o`=`hold_if_id_o`=`hold_id_ex_o`=1. One bubble is inserted into ID/EX.
  5. Otherwise all holds =0.
- `jump_addr_o` = `jump_addr_i` when `jump_i`=1, else 0.
- Timeout counter:
  - Cleared on entry to BUS_WAIT.
  - Increments each BUS_WAIT cycle. Saturating compare against `BUS_TMO`; no wrap.
- `div_done_i` arriving in RUN is ignored.
- A `div_start_i` during DIV_WAIT is ignored. This is a protocol violation.

## Timing
- Reset values (`rst`=0):
  - State = RUN, timeout counter = 0, `bus_err_o`=0, both perf counters = 0.
  - All combinational outputs are forced to 0 during reset.
- Jump and load-use take effect with 0 latency, in the same cycle.
- Divide stall:
  - `div_start_i` at cycle t: holds asserted from t+1 through the cycle before `div_done_i`.
  - Holds are released in the cycle `div_done_i`=1.
- Bus timeout: `bus_err_o` is high in the cycle after the `BUS_TMO`-th BUS_WAIT cycle. The FSM is in RUN in that same cycle.
- If `rst` asserts mid-stall, the next cycle after reset release is RUN with no holds.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt_o` increments each cycle `hold_pc_o`=1.
  - `flush_cnt_o` increments each cycle `jump_o`=1.
  - Both are 32-bit and wrap modulo 2^32.
- `PIPE_CTRL_PERF_EN` undefined: both outputs are tied to 0 and no counter flops are generated.

## Structure
- `pipe_ctrl_pkg` holds:
  - the state enum (RUN=2'd0, DIV_WAIT=2'd1, BUS_WAIT=2'd2);
  - the NOP encoding 32'h0000_0013 used by stage `set_data`.
- One sub-module, `pipe_ctrl_tmo`: clear/enable/saturating counter with a terminal-count output.

## Test plan
- Idle: no requests for 10 cycles → all holds 0, `jump_o`=0, state RUN.
- Jump: `jump_i`=1 with `jump_addr_i`=32'h0000_0100 for 1 cycle, `lu_hazard_i`=1 in the same cycle → same cycle `jump_o`=1, `jump_addr_o`=32'h100, `hold_if_id_o`=`hold_id_ex_o`=1, `hold_pc_o`=0.
- Divide: `div_start_i` at t, `div_done_i` at t+33 → all holds =1 for t+1..t+32, 0 at t+33. `stall_cnt_o` +=32 with PERF enabled.
- Bus timeout: `BUS_TMO`=4, `bus_hold_i` held high → `hold_pc_o`=1 for the RUN entry cycle plus 4 BUS_WAIT cycles, then `bus_err_o` pulses once and the FSM re-enters BUS_WAIT on the next cycle.
- Reset mid-divide: `rst`=0 at t+5 of a divide stall → holds drop immediately. After release, state is RUN and a late `div_done_i` is ignored.
- Macro off: repeat the divide scenario → `stall_cnt_o`=`flush_cnt_o`=0 throughout.
